addition_seq_n: RTL

- Parametrised successor to the fixed two-operand addition composition.
- Sums ICNT operands of BW bits each, one operand per clock, under the team's ST/RD start/ready handshake.
- Adds a busy indication and a sticky overflow flag.
- Sits as a leaf operation inside composition/recursion operator chains, driven by an upstream ST and consumed on RD.

---
 rtl/addition_pkg.sv | 37 +++
 rtl/addition_step.sv | 28 ++
 rtl/addition_seq_n.sv | 134 +++++++++++++
 3 files changed

// File: rtl/addition_pkg.sv
// Shared definitions for the sequential N-operand adder (addition_seq_n).
// Holds the controller state encoding and the width helper used to size
// the operand index counter.
package addition_pkg;

   // Controller states: wait for start, accumulate one operand per clock,
   // publish the result.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Index counter width; never narrower than one bit so ICNT=1 still
   // gets a legal counter.
   function automatic int idx_width(input int n);
      int w;
      w = clog2(n);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage : addition_pkg

// File: rtl/addition_step.sv
// One accumulation step: BW-bit add with carry-out.
// Build option ADDITION_SAT_EN: when defined, a step that carries out of
// bit BW-1 clamps its sum to all-ones. Because an all-ones accumulator plus
// any non-zero operand carries again (and plus zero stays all-ones), the
// clamp is sticky for the rest of an operation without extra state.
module addition_step #(
   parameter int BW = 16
) (
   input  logic [BW-1:0] acc,
   input  logic [BW-1:0] op,
   output logic [BW-1:0] sum,
   output logic          cout
);

   logic [BW:0] wide_s;

   // BW+1-bit adder; the top bit is the carry of this step.
   always_comb begin
      wide_s = {1'b0, acc} + {1'b0, op};
      cout   = wide_s[BW];
`ifdef ADDITION_SAT_EN
      sum    = wide_s[BW] ? {BW{1'b1}} : wide_s[BW-1:0];
`else
      sum    = wide_s[BW-1:0];
`endif
   end

endmodule : addition_step

// File: rtl/addition_seq_n.sv
// Sequential N-operand adder with ST/RD start/ready handshake.
// Latches ICNT packed operands on an accepted ST, adds one operand per
// clock, then pulses RD for one cycle with RES/OVF updated. BUSY covers
// the whole operation up to and including the RD cycle.
// Build option ADDITION_SAT_EN selects a saturating accumulator (see
// addition_step); handshake and latency do not change with it.
module addition_seq_n
   import addition_pkg::*;
#(
   parameter int BW   = 16,
   parameter int ICNT = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ST,
   input  logic [ICNT*BW-1:0] IN,
   output logic               RD,
   output logic [BW-1:0]      RES,
   output logic               OVF,
   output logic               BUSY
);

   localparam int            IW       = idx_width(ICNT);
   localparam logic [IW-1:0] LAST_IDX = IW'(ICNT - 1);

   state_e             state_q,   state_d;
   logic [IW-1:0]      idx_q,     idx_d;
   logic [BW-1:0]      acc_q,     acc_d;
   logic [ICNT*BW-1:0] op_q,      op_d;
   logic               ovf_run_q, ovf_run_d;
   logic [BW-1:0]      res_q,     res_d;
   logic               ovf_q,     ovf_d;
   logic               rd_q,      rd_d;
   logic               busy_q,    busy_d;

   logic [BW-1:0]      op_sel_s;
   logic [BW-1:0]      step_sum_s;
   logic               step_cout_s;

   // Operand for the current accumulation step, taken from the latched copy.
   always_comb begin
      op_sel_s = op_q[idx_q*BW +: BW];
   end

   addition_step #(
      .BW (BW)
   ) u_step (
      .acc  (acc_q),
      .op   (op_sel_s),
      .sum  (step_sum_s),
      .cout (step_cout_s)
   );

   // Next-state logic for the controller, datapath and registered outputs.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      op_d      = op_q;
      ovf_run_d = ovf_run_q;
      res_d     = res_q;
      ovf_d     = ovf_q;
      rd_d      = 1'b0;
      busy_d    = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (ST) begin
               // RES/OVF deliberately untouched: they hold until the next DONE.
               op_d      = IN;
               acc_d     = {BW{1'b0}};
               idx_d     = {IW{1'b0}};
               ovf_run_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_ACC;
            end else begin
               busy_d    = 1'b0;
            end
         end
         ST_ACC: begin
            // ST is ignored here; a busy operation never queues a restart.
            acc_d     = step_sum_s;
            ovf_run_d = ovf_run_q | step_cout_s;
            busy_d    = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IW'(1'b1);
            end
         end
         ST_DONE: begin
            res_d   = acc_q;
            ovf_d   = ovf_run_q;
            rd_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; RST aborts any operation on the same edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         idx_q     <= {IW{1'b0}};
         acc_q     <= {BW{1'b0}};
         op_q      <= {(ICNT*BW){1'b0}};
         ovf_run_q <= 1'b0;
         res_q     <= {BW{1'b0}};
         ovf_q     <= 1'b0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         op_q      <= op_d;
         ovf_run_q <= ovf_run_d;
         res_q     <= res_d;
         ovf_q     <= ovf_d;
         rd_q      <= rd_d;
         busy_q    <= busy_d;
      end
   end

   assign RD   = rd_q;
   assign RES  = res_q;
   assign OVF  = ovf_q;
   assign BUSY = busy_q;

endmodule : addition_seq_n
